pipe_issue_ctrl: RTL and testbench
==================================

# pipe_issue_ctrl

Central issue and hazard controller for the overlapped multi-cycle MIPS core. It shares one instruction-fetch path among N pipeline-slot FSMs:
- grants `ack` to one requesting slot per cycle, round-robin;
- pulses the PC/IR fetch strobe on each grant;
- tracks which slots hold live instructions;
- merges per-slot stall and flush requests into the single `bubble`/`bubblePri` and `flush`/`flushPri` broadcasts that every slot FSM compares against its own stage counter.

## Interface
- `N_SLOTS`, default 4: number of slot FSMs served (2..8).
- `STG_W`, default 3: width of a slot stage value and of the broadcast priorities.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_req` in N_SLOTS: slot idle or finishing, wants a new instruction.
- `slot_stage` in N_SLOTS*STG_W: current stage of each slot; slot i occupies bits [i*STG_W +: STG_W].
- `hazard_req` in N_SLOTS: slot detected a data or structural hazard and must stall.
- `flush_req` in N_SLOTS: slot resolved a taken branch or jump and younger work must be discarded.
- `mem_busy` in 1: shared memory port is in use by a data access, so no fetch this cycle.
- `ack` out N_SLOTS: one-hot-or-zero issue grant.
- `fetch_strobe` out 1: PCWrite/IR-capture pulse, equal to |ack.
- `bubble` out 1: stall broadcast.
- `bubblePri` out STG_W: stage threshold for the stall broadcast; slots with stage ≤ bubblePri stall.
- `flush` out 1: flush broadcast.
- `flushPri` out STG_W: stage threshold for the flush broadcast; slots with stage < flushPri flush.
- `active` out N_SLOTS: slot holds a live instruction.
- `issue_cnt` out 8: total grants since reset, wraps modulo 256.

## Operation
All outputs are registered, and all decisions use the inputs sampled at the clock edge.

**Priority each cycle: flush > bubble > grant.**

**Flush**
- Triggered when any bit of `flush_req` is set.
- Selected requester: the one with the largest `slot_stage`; ties go to the lowest index.
- Next cycle outputs: `flush`=1 and `flushPri`=selected stage.
- At that edge every active slot with stage < selected stage is cleared in `active`.
- No `ack` is issued in a flush cycle.

**Bubble**
- `bubble` = OR of `hazard_req` over active slots.
- `bubblePri` = largest stage among active requesters.
- While `bubble`=1 no `ack` is issued.
- Requests are level-based: `bubble` stays high as long as any request persists.
- `hazard_req` from inactive slots is ignored.

**Grant**
- Eligible slots: `fetch_req`=1, no flush or bubble this cycle, and `mem_busy`=0.
- Winner: round-robin, starting from the index after the last granted slot, wrapping at N_SLOTS-1. The pointer resets to slot 0 as first candidate.
- On grant:
  - `ack[w]`=1 for one cycle;
  - `active[w]`=1;
  - `issue_cnt`+1.
- A slot that is active and asserts `fetch_req` is retiring: its `active` bit clears at that edge unless the same slot is granted in that same cycle.

**Reset values**
- `ack`=0, `fetch_strobe`=0, `bubble`=0, `flush`=0, `bubblePri`=0, `flushPri`=0, `active`=0, `issue_cnt`=0.
- Round-robin pointer = N_SLOTS-1, so slot 0 is the first candidate.

**Boundary conditions**
- Reset asserted mid-operation clears all state immediately (asynchronous).
- `flush_req` and `hazard_req` in the same cycle: only the flush is acted on; `bubble`=0 in that output cycle.
- The flushing slot itself is never cleared (strict less-than comparison).
- `mem_busy` held high starves grants but not flush or bubble.

## Timing
- Request → `ack`/`flush`/`bubble`: latency 1 cycle.
- `ack` and `fetch_strobe`: exactly one cycle wide per grant.
- `flush`: exactly one cycle wide per sampled `flush_req` cycle. A `flush_req` held for k cycles produces k pulses; slots deassert `flush_req` after one cycle.
- Throughput: at most one grant per cycle. Back-to-back grants to different slots are allowed.

## Structure
- Shared package `pipe_pkg`: `STG_W` default, the slot stage encoding constants (stage 0 = fetch), and the `N_SLOTS` default.
- Sub-module `rr_arbiter`: parameterized round-robin arbiter with request vector, enable, one-hot grant output, and pointer update on grant. Reusable for the data-memory port.
- Max-stage selection (flush and bubble) is done with a combinational loop in the top level.

## Test plan
- **Basic grant:** after reset, `fetch_req`=4'b1111, `mem_busy`=0 → `ack` sequence 0001, 0010, 0100, 1000, 0001; `issue_cnt`=5.
- **Memory back-pressure:** `fetch_req`=4'b0100 with `mem_busy`=1 for 3 cycles → `ack`=0 throughout. Deassert `mem_busy` → `ack`=4'b0100 one cycle later.
- **Bubble:**
  - Setup: slots 0 and 1 active at stages 3 and 1; slot 0 asserts `hazard_req`.
  - Required: `bubble`=1 and `bubblePri`=3 next cycle; no `ack` while held.
  - Release `hazard_req`: `bubble`=0 one cycle later.
- **Flush:**
  - Setup: slots 0, 1, 2 active at stages 4, 2, 0; slot 0 raises `flush_req` for one cycle.
  - Required: `flush`=1, `flushPri`=4; `active` becomes 4'b0001.
- **Flush beats bubble:**
  - Setup: `flush_req` from slot 2 (stage 3) and `hazard_req` from slot 1 in the same cycle.
  - Required: `flush`=1, `flushPri`=3, `bubble`=0, `ack`=0.
- **Reset mid-operation:** assert `rst_n`=0 while `ack`=1 and `active`=4'b0111 → all outputs 0 immediately. First grant after release goes to slot 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared defaults and stage encoding for the pipeline slot controllers
package pipe_pkg;

  localparam int N_SLOTS_DEF = 4;
  localparam int STG_W_DEF   = 3;

  // Stage 0 is fetch; larger values are further down the pipe (older work).
  typedef enum logic [STG_W_DEF-1:0] {
    STG_IF  = 3'd0,
    STG_ID  = 3'd1,
    STG_EX  = 3'd2,
    STG_MEM = 3'd3,
    STG_WB  = 3'd4
  } stage_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer advances only on grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        ptr_d      = PW'(idx);
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// rtl/pipe_issue_ctrl.sv - shared fetch grant plus stall/flush broadcast for the slot FSMs
module pipe_issue_ctrl
  import pipe_pkg::*;
#(
  parameter int N_SLOTS = N_SLOTS_DEF,
  parameter int STG_W   = STG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SLOTS-1:0]       fetch_req,
  input  logic [N_SLOTS*STG_W-1:0] slot_stage,
  input  logic [N_SLOTS-1:0]       hazard_req,
  input  logic [N_SLOTS-1:0]       flush_req,
  input  logic                     mem_busy,
  output logic [N_SLOTS-1:0]       ack,
  output logic                     fetch_strobe,
  output logic                     bubble,
  output logic [STG_W-1:0]         bubblePri,
  output logic                     flush,
  output logic [STG_W-1:0]         flushPri,
  output logic [N_SLOTS-1:0]       active,
  output logic [7:0]               issue_cnt
);

  logic [N_SLOTS-1:0] ack_q, ack_d, active_q, active_d, grant, kill;
  logic               strobe_q, strobe_d, bubble_q, bubble_d, flush_q, flush_d;
  logic [STG_W-1:0]   bubble_pri_q, bubble_pri_d, flush_pri_q, flush_pri_d;
  logic [STG_W-1:0]   f_sel, b_sel, stg;
  logic               f_any, b_any, grant_en;
  logic [7:0]         issue_cnt_q, issue_cnt_d;

  // Oldest requester wins; strict '>' keeps the lowest index on ties.
  always_comb begin
    f_sel = STG_W'(STG_IF);
    b_sel = STG_W'(STG_IF);
    f_any = 1'b0;
    b_any = 1'b0;
    stg   = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      stg = slot_stage[i*STG_W +: STG_W];
      if (flush_req[i] && (!f_any || stg > f_sel)) begin
        f_sel = stg;
        f_any = 1'b1;
      end
      if (active_q[i] && hazard_req[i] && (!b_any || stg > b_sel)) begin
        b_sel = stg;
        b_any = 1'b1;
      end
    end
  end

  assign grant_en = !f_any && !b_any && !mem_busy;

  rr_arbiter #(.N(N_SLOTS)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (fetch_req),
    .en    (grant_en),
    .grant (grant)
  );

  always_comb begin
    kill = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (f_any && slot_stage[i*STG_W +: STG_W] < f_sel) kill[i] = 1'b1;
    end
    ack_d        = grant;
    strobe_d     = |grant;
    flush_d      = f_any;
    flush_pri_d  = f_any ? f_sel : STG_W'(STG_IF);
    bubble_d     = b_any && !f_any;
    bubble_pri_d = bubble_d ? b_sel : STG_W'(STG_IF);
    // Retiring slots (active and asking to fetch) drop out unless re-granted now.
    active_d     = (active_q & ~kill & ~(fetch_req & ~grant)) | grant;
    issue_cnt_d  = issue_cnt_q + 8'(|grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q        <= '0;
      strobe_q     <= 1'b0;
      bubble_q     <= 1'b0;
      bubble_pri_q <= '0;
      flush_q      <= 1'b0;
      flush_pri_q  <= '0;
      active_q     <= '0;
      issue_cnt_q  <= '0;
    end else begin
      ack_q        <= ack_d;
      strobe_q     <= strobe_d;
      bubble_q     <= bubble_d;
      bubble_pri_q <= bubble_pri_d;
      flush_q      <= flush_d;
      flush_pri_q  <= flush_pri_d;
      active_q     <= active_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  assign ack          = ack_q;
  assign fetch_strobe = strobe_q;
  assign bubble       = bubble_q;
  assign bubblePri    = bubble_pri_q;
  assign flush        = flush_q;
  assign flushPri     = flush_pri_q;
  assign active       = active_q;
  assign issue_cnt    = issue_cnt_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// tb/tb_pipe_issue_ctrl.sv - directed self-checking bench for pipe_issue_ctrl
module tb_pipe_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fetch_req, hazard_req, flush_req;
  logic [11:0] slot_stage;
  logic        mem_busy;
  logic [3:0]  ack, active;
  logic        fetch_strobe, bubble, flush;
  logic [2:0]  bubblePri, flushPri;
  logic [7:0]  issue_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_issue_ctrl #(.N_SLOTS(4), .STG_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .slot_stage(slot_stage),
    .hazard_req(hazard_req), .flush_req(flush_req), .mem_busy(mem_busy),
    .ack(ack), .fetch_strobe(fetch_strobe), .bubble(bubble), .bubblePri(bubblePri),
    .flush(flush), .flushPri(flushPri), .active(active), .issue_cnt(issue_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_stages(input logic [2:0] s0, s1, s2, s3);
    slot_stage = {s3, s2, s1, s0};
  endtask

  task automatic idle_inputs();
    fetch_req = 4'b0; hazard_req = 4'b0; flush_req = 4'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    set_stages(3'd0, 3'd0, 3'd0, 3'd0);
    step(); step();
    n_checks++; if (ack !== 4'b0)       begin n_fail++; $display("FAIL reset_ack got %b exp 0000", ack); end
    n_checks++; if (fetch_strobe !== 0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", fetch_strobe); end
    n_checks++; if (bubble !== 0 || bubblePri !== 3'd0) begin n_fail++; $display("FAIL reset_bubble got %b/%0d exp 0/0", bubble, bubblePri); end
    n_checks++; if (flush !== 0 || flushPri !== 3'd0)   begin n_fail++; $display("FAIL reset_flush got %b/%0d exp 0/0", flush, flushPri); end
    n_checks++; if (active !== 4'b0)    begin n_fail++; $display("FAIL reset_active got %b exp 0000", active); end
    n_checks++; if (issue_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", issue_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_grant();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fetch_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (ack !== exp_seq[i]) begin n_fail++; $display("FAIL grant_ack[%0d] got %b exp %b", i, ack, exp_seq[i]); end
      n_checks++; if (fetch_strobe !== 1'b1) begin n_fail++; $display("FAIL grant_strobe[%0d] got %b exp 1", i, fetch_strobe); end
    end
    fetch_req = 4'b0;
    step();
    n_checks++; if (ack !== 4'b0 || fetch_strobe !== 0) begin n_fail++; $display("FAIL grant_idle got %b/%b exp 0000/0", ack, fetch_strobe); end
    n_checks++; if (issue_cnt !== 8'd5) begin n_fail++; $display("FAIL grant_cnt got %0d exp 5", issue_cnt); end
    n_checks++; if (active !== 4'b0001) begin n_fail++; $display("FAIL grant_active got %b exp 0001", active); end
  endtask

  task automatic test_mem_backpressure();
    fetch_req = 4'b0001; mem_busy = 1'b1;
    step();
    n_checks++; if (ack !== 4'b0 || active !== 4'b0) begin n_fail++; $display("FAIL retire got ack %b active %b exp 0000/0000", ack, active); end
    fetch_req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL mem_busy_ack[%0d] got %b exp 0000", i, ack); end
    end
    mem_busy = 1'b0;
    step();
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL mem_release_ack got %b exp 0100", ack); end
    n_checks++; if (issue_cnt !== 8'd6) begin n_fail++; $display("FAIL mem_release_cnt got %0d exp 6", issue_cnt); end
    fetch_req = 4'b0;
    step();
  endtask

  task automatic test_bubble();
    fetch_req = 4'b0100; mem_busy = 1'b1;
    step();
    mem_busy = 1'b0; fetch_req = 4'b0001;
    step();
    fetch_req = 4'b0010;
    step();
    n_checks++; if (active !== 4'b0011) begin n_fail++; $display("FAIL bubble_setup_active got %b exp 0011", active); end
    set_stages(3'd3, 3'd1, 3'd0, 3'd7);
    fetch_req = 4'b0100; hazard_req = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bubble !== 1'b1 || bubblePri !== 3'd3) begin n_fail++; $display("FAIL bubble_held[%0d] got %b/%0d exp 1/3", i, bubble, bubblePri); end
      n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL bubble_ack[%0d] got %b exp 0000", i, ack); end
    end
    hazard_req = 4'b1000;
    step();
    n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL bubble_release got %b exp 0", bubble); end
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL bubble_release_ack got %b exp 0100", ack); end
    idle_inputs();
    step();
    n_checks++; if (active !== 4'b0111 || issue_cnt !== 8'd9) begin n_fail++; $display("FAIL bubble_after got %b/%0d exp 0111/9", active, issue_cnt); end
  endtask

  task automatic test_flush();
    set_stages(3'd4, 3'd2, 3'd0, 3'd0);
    flush_req = 4'b0001; fetch_req = 4'b1000;
    step();
    n_checks++; if (flush !== 1'b1 || flushPri !== 3'd4) begin n_fail++; $display("FAIL flush_out got %b/%0d exp 1/4", flush, flushPri); end
    n_checks++; if (active !== 4'b0001) begin n_fail++; $display("FAIL flush_active got %b exp 0001", active); end
    n_checks++; if (ack !== 4'b0) begin n_fail++; $display("FAIL flush_ack got %b exp 0000", ack); end
    idle_inputs();
    step();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL flush_width got %b exp 0", flush); end
  endtask

  task automatic test_flush_beats_bubble();
    fetch_req = 4'b0010;
    step();
    n_checks++; if (active !== 4'b0011) begin n_fail++; $display("FAIL fb_setup_active got %b exp 0011", active); end
    set_stages(3'd4, 3'd1, 3'd3, 3'd0);
    fetch_req = 4'b0100; flush_req = 4'b0100; hazard_req = 4'b0010;
    step();
    n_checks++; if (flush !== 1'b1 || flushPri !== 3'd3) begin n_fail++; $display("FAIL fb_flush got %b/%0d exp 1/3", flush, flushPri); end
    n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL fb_bubble got %b exp 0", bubble); end
    n_checks++; if (ack !== 4'b0 || active !== 4'b0001) begin n_fail++; $display("FAIL fb_ack_active got %b/%b exp 0000/0001", ack, active); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back_and_reset_mid();
    fetch_req = 4'b0010;
    step();
    fetch_req = 4'b0100;
    step();
    n_checks++; if (ack !== 4'b0100 || active !== 4'b0111) begin n_fail++; $display("FAIL b2b got %b/%b exp 0100/0111", ack, active); end
    n_checks++; if (issue_cnt !== 8'd12) begin n_fail++; $display("FAIL b2b_cnt got %0d exp 12", issue_cnt); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ack !== 4'b0 || fetch_strobe !== 0 || active !== 4'b0 || issue_cnt !== 8'd0) begin
      n_fail++; $display("FAIL async_reset got %b/%b/%b/%0d exp 0", ack, fetch_strobe, active, issue_cnt);
    end
    fetch_req = 4'b1111;
    step();
    rst_n = 1'b1;
    step();
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL post_reset_ack got %b exp 0001", ack); end
    n_checks++; if (issue_cnt !== 8'd1) begin n_fail++; $display("FAIL post_reset_cnt got %0d exp 1", issue_cnt); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_mem_backpressure();
    test_bubble();
    test_flush();
    test_flush_beats_bubble();
    test_back_to_back_and_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
